// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity and stop-bit settings
// used by both uart_tx and uart_rx so the two ends always agree on framing.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START_BIT,
    RX_DATA,
    RX_PARITY_BIT,
    RX_STOP_BIT,
    RX_WAIT_HIGH
  } uart_rx_state_t;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_XOR  = 2'b01;
  localparam logic [1:0] PARITY_XNOR = 2'b10;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  // Parity bit a transmitter would place after the data for the given mode.
  function automatic logic parity_bit(input logic [1:0] mode, input logic [7:0] data);
    return (mode == PARITY_XNOR) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver line and word-report bundle; master is the receiver, slave the consumer
// that also owns the serial line.
interface uart_rx_if;
  logic       dataIn;
  logic [7:0] dataOut;
  logic       valid;
  logic       parityErr;
  logic       frameErr;
  logic       busy;

  modport master (input dataIn, output dataOut, valid, parityErr, frameErr, busy);
  modport slave  (output dataIn, input dataOut, valid, parityErr, frameErr, busy);
endinterface

// File: rtl/uart_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input, with a
// configurable reset value so an idle-high line does not look like a fall.
module uart_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) sync_reg[0] <= RESET_VAL;
    else        sync_reg[0] <= d;
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk) begin
      if (!rst_n) sync_reg[gi] <= RESET_VAL;
      else        sync_reg[gi] <= sync_reg[gi-1];
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: mid-bit sampling of a synchronized line, 8 data bits LSB first,
// optional parity and one or two stop bits, one-cycle valid with error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int         PRESCALER_COUNT = 234,
  parameter logic [1:0] PARITY          = PARITY_NONE,
  parameter logic       STOP_BITS       = STOP_ONE
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master rx
);

  localparam int CNT_W = (PRESCALER_COUNT > 0) ? $clog2(PRESCALER_COUNT + 1) : 1;
  localparam logic [CNT_W-1:0] FULL_C = CNT_W'(PRESCALER_COUNT);
  localparam logic [CNT_W-1:0] HALF_C = CNT_W'(PRESCALER_COUNT / 2);
  localparam logic PAR_EN = (PARITY == PARITY_XOR) || (PARITY == PARITY_XNOR);

  uart_rx_state_t   state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             par_flag_reg, par_flag_next;
  logic             frame_flag_reg, frame_flag_next;
  logic             stop_idx_reg, stop_idx_next;
  logic [7:0]       data_out_reg, data_out_next;
  logic             valid_reg, valid_next;
  logic             perr_reg, perr_next;
  logic             ferr_reg, ferr_next;
  logic             rx_s, rx_prev_reg;
  logic [1:0]       settle_reg;
  logic             armed_reg;
  logic             fall, frame_acc;

  uart_sync #(.STAGES(2), .RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx.dataIn),
    .q     (rx_s)
  );

  // Edges are only trusted once the synchronizer has flushed its reset value and
  // the line has been seen high, so a line held low across reset cannot frame.
  assign fall      = armed_reg && rx_prev_reg && !rx_s;
  assign frame_acc = frame_flag_reg | ~rx_s;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= RX_IDLE;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      par_flag_reg   <= 1'b0;
      frame_flag_reg <= 1'b0;
      stop_idx_reg   <= 1'b0;
      data_out_reg   <= 8'h00;
      valid_reg      <= 1'b0;
      perr_reg       <= 1'b0;
      ferr_reg       <= 1'b0;
      rx_prev_reg    <= 1'b1;
      settle_reg     <= 2'b00;
      armed_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      idx_reg        <= idx_next;
      shift_reg      <= shift_next;
      par_flag_reg   <= par_flag_next;
      frame_flag_reg <= frame_flag_next;
      stop_idx_reg   <= stop_idx_next;
      data_out_reg   <= data_out_next;
      valid_reg      <= valid_next;
      perr_reg       <= perr_next;
      ferr_reg       <= ferr_next;
      rx_prev_reg    <= rx_s;
      settle_reg     <= {settle_reg[0], 1'b1};
      if (settle_reg[1] && rx_s) armed_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    idx_next        = idx_reg;
    shift_next      = shift_reg;
    par_flag_next   = par_flag_reg;
    frame_flag_next = frame_flag_reg;
    stop_idx_next   = stop_idx_reg;
    data_out_next   = data_out_reg;
    valid_next      = 1'b0;
    perr_next       = perr_reg;
    ferr_next       = ferr_reg;

    case (state_reg)
      RX_IDLE: begin
        if (fall) begin
          cnt_next   = '0;
          state_next = RX_START_BIT;
        end
      end
      RX_START_BIT: begin
        if (cnt_reg == HALF_C) begin
          cnt_next = '0;
          if (rx_s) begin
            state_next = RX_IDLE;
          end else begin
            idx_next        = '0;
            par_flag_next   = 1'b0;
            frame_flag_next = 1'b0;
            stop_idx_next   = 1'b0;
            state_next      = RX_DATA;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_reg == FULL_C) begin
          cnt_next   = '0;
          shift_next = {rx_s, shift_reg[7:1]};
          idx_next   = idx_reg + 3'd1;
          if (idx_reg == 3'd7) state_next = PAR_EN ? RX_PARITY_BIT : RX_STOP_BIT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_PARITY_BIT: begin
        if (cnt_reg == FULL_C) begin
          cnt_next      = '0;
          par_flag_next = (rx_s != parity_bit(PARITY, shift_reg));
          state_next    = RX_STOP_BIT;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_STOP_BIT: begin
        if (cnt_reg == FULL_C) begin
          cnt_next = '0;
          if ((STOP_BITS == STOP_TWO) && !stop_idx_reg) begin
            stop_idx_next   = 1'b1;
            frame_flag_next = frame_acc;
          end else begin
            valid_next    = 1'b1;
            data_out_next = shift_reg;
            perr_next     = par_flag_reg;
            ferr_next     = frame_acc;
            state_next    = frame_acc ? RX_WAIT_HIGH : RX_IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) state_next = RX_IDLE;
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign rx.dataOut   = data_out_reg;
  assign rx.valid     = valid_reg;
  assign rx.parityErr = perr_reg;
  assign rx.frameErr  = ferr_reg;
  assign rx.busy      = (state_reg != RX_IDLE);

endmodule
